dac_cfg_sched: RTL and testbench
================================

DAC_CFG_SCHED -- requirements
Module: dac_cfg_sched

Interface
REQ-001 The block SHALL have parameter INIT_LEN, default 8, giving the number of init-table entries (1..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 1023, giving the maximum cycles to wait for transaction completion.
REQ-003 cfg_spi_clk  in  1  sole clock; all logic on the rising edge.
REQ-004 cfg_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 init_start  in  1  one-cycle pulse that starts the init-table sequence.
REQ-006 init_rom_addr  out  4  init-table index; the table returns data one cycle after the address changes.
REQ-007 init_rom_data  in  40  table entry, {addr[39:32], data[31:0]}.
REQ-008 host_wr_req/host_wr_addr/host_wr_data  in  1/8/32  level write request, held until host_wr_ack.
REQ-009 host_wr_ack  out  1  one-cycle pulse when the write completes.
REQ-010 host_rd_req/host_rd_addr  in  1/8  level readback request, held until host_rd_ack.
REQ-011 host_rd_ack/host_rd_data  out  1/32  one-cycle ack; the data is valid in the ack cycle and held afterwards.
REQ-012 dac_cfg_valid/dac_cfg_addr/dac_cfg_data/spi_rd_en  out  1/8/32/1  transaction issue towards dac_cfg.
REQ-013 dac_spi_end/dac_rd_valid/dac_rd_parameter  in  1/1/32  completion and readback from dac_cfg.
REQ-014 dac_ioup_req  out  1  one-cycle IO-update request.
REQ-015 sched_busy/init_done/timeout_err  out  1/1/1  status outputs.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, ISSUE, WAIT and IOUP; exactly one transaction SHALL be outstanding at a time.
REQ-017 In IDLE, arbitration priority SHALL be: init_start > host_wr_req > host_rd_req, evaluated in one cycle.
REQ-018 init_start SHALL clear the index to 0, clear init_done and timeout_err, then enter FETCH.
- If init_start arrives in a non-IDLE state, it SHALL be latched as pending.
- The pending start SHALL be served at the next IDLE.
REQ-019 FETCH SHALL last exactly one cycle, with init_rom_addr = index, and SHALL then go to ISSUE.
REQ-020 ISSUE SHALL assert dac_cfg_valid for exactly one cycle.
- addr/data SHALL come from the table entry or the host inputs.
- spi_rd_en SHALL be 1 only for a host read.
- addr/data/spi_rd_en SHALL hold stable until the transaction leaves WAIT.
REQ-021 WAIT SHALL count cycles from 0.
- A write or init transaction completes on dac_spi_end.
- A read completes on dac_rd_valid, capturing dac_rd_parameter into host_rd_data.
- For a read, dac_spi_end without dac_rd_valid SHALL be ignored.
REQ-022 On init completion, the index SHALL increment.
- If index+1 < INIT_LEN, the FSM SHALL go to FETCH.
- Otherwise it SHALL set init_done and go to IOUP.
REQ-023 On host write completion, the block SHALL pulse host_wr_ack in the following cycle and go to IOUP.
REQ-024 On host read completion, the block SHALL pulse host_rd_ack in the following cycle and return to IDLE with no IOUP.
REQ-025 IOUP SHALL pulse dac_ioup_req for one cycle, then return to IDLE.
REQ-026 If the counter in WAIT reaches TIMEOUT, the block SHALL set timeout_err (sticky) and take the following action:
- init: abort, init_done stays 0, go to IDLE;
- host write/read: still pulse the ack, host_rd_data = 32'hFFFF_FFFF, no IOUP.
REQ-027 A completion input that coincides with the TIMEOUT cycle SHALL count as success.
REQ-028 Completion inputs outside WAIT SHALL be ignored.
REQ-029 sched_busy SHALL be 1 in every state except IDLE.
REQ-030 A host request dropped before its ack SHALL NOT abort an in-flight transaction; the ack is still pulsed.

Reset
REQ-031 Assertion of cfg_rst_n=0 SHALL immediately force IDLE and clear all of the following to 0:
- every output: dac_cfg_valid, dac_cfg_addr, dac_cfg_data, spi_rd_en, host_wr_ack, host_rd_ack, host_rd_data, dac_ioup_req, sched_busy, init_done, timeout_err, init_rom_addr;
- the index, the WAIT counter and the pending-init latch.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no ack; operation SHALL resume one cycle after deassertion.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- INIT_LEN=3, table {0x00:0x0000_0002, 0x0E:0x0A0B_0C0D, 0x01:0x0140_0820}, dac_spi_end 20 cycles after each valid -> 3 valid pulses with matching addr/data, then one dac_ioup_req, init_done=1.
- host_wr_req addr 0x0E data 0x1234_5678 -> valid with spi_rd_en=0; ack 1 cycle after dac_spi_end; dac_ioup_req in the next cycle.
- host_rd_req addr 0x0E, dac_rd_valid with 0xCAFE_F00D -> host_rd_ack with host_rd_data=0xCAFE_F00D; no dac_ioup_req.
- host_wr_req and host_rd_req raised in the same IDLE cycle -> write served first, read served immediately after.
- TIMEOUT=15, no dac_spi_end -> timeout_err=1 at wait cycle 15; ack pulsed; a later init_start clears timeout_err.
- cfg_rst_n low during WAIT of init entry 1 -> all outputs 0 immediately; a new init_start restarts at index 0.

Source files
------------

// File: rtl/dac_cfg_sched_if.sv
// Bundle between the DAC config scheduler and its init table, host port and dac_cfg engine.
// The master modport is the scheduler side; the slave modport is everything around it.
interface dac_cfg_sched_if;
    logic        init_start;
    logic [3:0]  init_rom_addr;
    logic [39:0] init_rom_data;
    logic        host_wr_req;
    logic [7:0]  host_wr_addr;
    logic [31:0] host_wr_data;
    logic        host_wr_ack;
    logic        host_rd_req;
    logic [7:0]  host_rd_addr;
    logic        host_rd_ack;
    logic [31:0] host_rd_data;
    logic        dac_cfg_valid;
    logic [7:0]  dac_cfg_addr;
    logic [31:0] dac_cfg_data;
    logic        spi_rd_en;
    logic        dac_spi_end;
    logic        dac_rd_valid;
    logic [31:0] dac_rd_parameter;
    logic        dac_ioup_req;
    logic        sched_busy;
    logic        init_done;
    logic        timeout_err;

    modport master (
        input  init_start, init_rom_data,
        input  host_wr_req, host_wr_addr, host_wr_data,
        input  host_rd_req, host_rd_addr,
        input  dac_spi_end, dac_rd_valid, dac_rd_parameter,
        output init_rom_addr, host_wr_ack, host_rd_ack, host_rd_data,
        output dac_cfg_valid, dac_cfg_addr, dac_cfg_data, spi_rd_en,
        output dac_ioup_req, sched_busy, init_done, timeout_err
    );

    modport slave (
        output init_start, init_rom_data,
        output host_wr_req, host_wr_addr, host_wr_data,
        output host_rd_req, host_rd_addr,
        output dac_spi_end, dac_rd_valid, dac_rd_parameter,
        input  init_rom_addr, host_wr_ack, host_rd_ack, host_rd_data,
        input  dac_cfg_valid, dac_cfg_addr, dac_cfg_data, spi_rd_en,
        input  dac_ioup_req, sched_busy, init_done, timeout_err
    );
endinterface

// File: rtl/dac_cfg_sched.sv
// DAC configuration scheduler: replays the init table, then serves host writes/reads,
// one dac_cfg transaction at a time, with a per-transaction completion timeout.
module dac_cfg_sched #(
    parameter int unsigned INIT_LEN = 8,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic            cfg_spi_clk,
    input  logic            cfg_rst_n,
    dac_cfg_sched_if.master bus
);
    localparam int unsigned IDX_W = 4;
    localparam int unsigned NXT_W = IDX_W + 1;
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, IOUP} state_t;
    typedef enum logic [1:0] {KIND_INIT, KIND_WR, KIND_RD} kind_t;

    state_t             state;
    kind_t              kind;
    logic [IDX_W-1:0]   index;
    logic [CNT_W-1:0]   wait_cnt;
    logic               init_pend;

    logic               start_c;
    logic               done_c;
    logic               last_c;
    logic               timeout_c;
    logic [NXT_W-1:0]   next_idx_c;

    assign start_c    = bus.init_start | init_pend;
    assign next_idx_c = {1'b0, index} + NXT_W'(1);
    assign last_c     = next_idx_c >= NXT_W'(INIT_LEN);
    // A read only completes on returned data; a bare spi_end is not enough.
    assign done_c     = (kind == KIND_RD) ? bus.dac_rd_valid : bus.dac_spi_end;
    assign timeout_c  = wait_cnt == CNT_W'(TIMEOUT);

    always_ff @(posedge cfg_spi_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            state             <= IDLE;
            kind              <= KIND_INIT;
            index             <= '0;
            wait_cnt          <= '0;
            init_pend         <= 1'b0;
            bus.init_rom_addr <= '0;
            bus.host_wr_ack   <= 1'b0;
            bus.host_rd_ack   <= 1'b0;
            bus.host_rd_data  <= '0;
            bus.dac_cfg_valid <= 1'b0;
            bus.dac_cfg_addr  <= '0;
            bus.dac_cfg_data  <= '0;
            bus.spi_rd_en     <= 1'b0;
            bus.dac_ioup_req  <= 1'b0;
            bus.sched_busy    <= 1'b0;
            bus.init_done     <= 1'b0;
            bus.timeout_err   <= 1'b0;
        end else begin
            bus.dac_cfg_valid <= 1'b0;
            bus.host_wr_ack   <= 1'b0;
            bus.host_rd_ack   <= 1'b0;
            bus.dac_ioup_req  <= 1'b0;
            if (bus.init_start && state != IDLE) begin
                init_pend <= 1'b1;
            end

            unique case (state)
                // Ack guards stop a still-held request from re-arming in its own ack cycle.
                IDLE: begin
                    if (start_c) begin
                        init_pend         <= 1'b0;
                        index             <= '0;
                        bus.init_rom_addr <= '0;
                        bus.init_done     <= 1'b0;
                        bus.timeout_err   <= 1'b0;
                        kind              <= KIND_INIT;
                        bus.sched_busy    <= 1'b1;
                        state             <= FETCH;
                    end else if (bus.host_wr_req && !bus.host_wr_ack) begin
                        kind              <= KIND_WR;
                        bus.dac_cfg_addr  <= bus.host_wr_addr;
                        bus.dac_cfg_data  <= bus.host_wr_data;
                        bus.spi_rd_en     <= 1'b0;
                        bus.sched_busy    <= 1'b1;
                        state             <= ISSUE;
                    end else if (bus.host_rd_req && !bus.host_rd_ack) begin
                        kind              <= KIND_RD;
                        bus.dac_cfg_addr  <= bus.host_rd_addr;
                        bus.dac_cfg_data  <= '0;
                        bus.spi_rd_en     <= 1'b1;
                        bus.sched_busy    <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                FETCH: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (kind == KIND_INIT) begin
                        bus.dac_cfg_addr <= bus.init_rom_data[39:32];
                        bus.dac_cfg_data <= bus.init_rom_data[31:0];
                        bus.spi_rd_en    <= 1'b0;
                    end
                    bus.dac_cfg_valid <= 1'b1;
                    wait_cnt          <= '0;
                    state             <= WAIT;
                end
                // Completion is checked before the limit so a same-cycle completion wins.
                WAIT: begin
                    if (done_c) begin
                        unique case (kind)
                            KIND_INIT: begin
                                index <= IDX_W'(next_idx_c);
                                if (last_c) begin
                                    bus.init_done <= 1'b1;
                                    state         <= IOUP;
                                end else begin
                                    bus.init_rom_addr <= IDX_W'(next_idx_c);
                                    state             <= FETCH;
                                end
                            end
                            KIND_WR: begin
                                bus.host_wr_ack <= 1'b1;
                                state           <= IOUP;
                            end
                            default: begin
                                bus.host_rd_data <= bus.dac_rd_parameter;
                                bus.host_rd_ack  <= 1'b1;
                                bus.sched_busy   <= 1'b0;
                                state            <= IDLE;
                            end
                        endcase
                    end else if (timeout_c) begin
                        bus.timeout_err <= 1'b1;
                        bus.sched_busy  <= 1'b0;
                        state           <= IDLE;
                        if (kind == KIND_WR) begin
                            bus.host_wr_ack <= 1'b1;
                        end
                        if (kind == KIND_RD) begin
                            bus.host_rd_ack  <= 1'b1;
                            bus.host_rd_data <= 32'hFFFF_FFFF;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                IOUP: begin
                    bus.dac_ioup_req <= 1'b1;
                    bus.sched_busy   <= 1'b0;
                    state            <= IDLE;
                end
                default: begin
                    bus.sched_busy <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_cfg_sched.sv
// Directed + randomized bench for dac_cfg_sched: one instance with a long timeout,
// one with TIMEOUT=15, sharing stimulus; outputs of the selected instance are checked.
module tb_dac_cfg_sched;
    localparam int TO_A = 1023;
    localparam int TO_B = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        init_start, wr_req, rd_req, spi_end, rd_valid, sel;
    logic [7:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_param;
    logic [39:0] rom_tbl [16];
    logic [39:0] rom_a, rom_b;

    dac_cfg_sched_if if_a ();
    dac_cfg_sched_if if_b ();

    dac_cfg_sched #(.INIT_LEN(3), .TIMEOUT(TO_A)) dut_a (.cfg_spi_clk(clk), .cfg_rst_n(rst_n), .bus(if_a));
    dac_cfg_sched #(.INIT_LEN(3), .TIMEOUT(TO_B)) dut_b (.cfg_spi_clk(clk), .cfg_rst_n(rst_n), .bus(if_b));

    // Synchronous table: data appears one cycle after the address.
    always_ff @(posedge clk) begin
        rom_a <= rom_tbl[if_a.init_rom_addr];
        rom_b <= rom_tbl[if_b.init_rom_addr];
    end

    assign if_a.init_start = init_start;       assign if_b.init_start = init_start;
    assign if_a.init_rom_data = rom_a;         assign if_b.init_rom_data = rom_b;
    assign if_a.host_wr_req = wr_req;          assign if_b.host_wr_req = wr_req;
    assign if_a.host_wr_addr = wr_addr;        assign if_b.host_wr_addr = wr_addr;
    assign if_a.host_wr_data = wr_data;        assign if_b.host_wr_data = wr_data;
    assign if_a.host_rd_req = rd_req;          assign if_b.host_rd_req = rd_req;
    assign if_a.host_rd_addr = rd_addr;        assign if_b.host_rd_addr = rd_addr;
    assign if_a.dac_spi_end = spi_end;         assign if_b.dac_spi_end = spi_end;
    assign if_a.dac_rd_valid = rd_valid;       assign if_b.dac_rd_valid = rd_valid;
    assign if_a.dac_rd_parameter = rd_param;   assign if_b.dac_rd_parameter = rd_param;

    logic        o_valid, o_rd_en, o_wr_ack, o_rd_ack, o_ioup, o_busy, o_done, o_err;
    logic [7:0]  o_addr;
    logic [31:0] o_data, o_rd_data;
    logic [3:0]  o_rom_addr;
    assign o_valid    = sel ? if_b.dac_cfg_valid : if_a.dac_cfg_valid;
    assign o_addr     = sel ? if_b.dac_cfg_addr  : if_a.dac_cfg_addr;
    assign o_data     = sel ? if_b.dac_cfg_data  : if_a.dac_cfg_data;
    assign o_rd_en    = sel ? if_b.spi_rd_en     : if_a.spi_rd_en;
    assign o_wr_ack   = sel ? if_b.host_wr_ack   : if_a.host_wr_ack;
    assign o_rd_ack   = sel ? if_b.host_rd_ack   : if_a.host_rd_ack;
    assign o_rd_data  = sel ? if_b.host_rd_data  : if_a.host_rd_data;
    assign o_ioup     = sel ? if_b.dac_ioup_req  : if_a.dac_ioup_req;
    assign o_busy     = sel ? if_b.sched_busy    : if_a.sched_busy;
    assign o_done     = sel ? if_b.init_done     : if_a.init_done;
    assign o_err      = sel ? if_b.timeout_err   : if_a.timeout_err;
    assign o_rom_addr = sel ? if_b.init_rom_addr : if_a.init_rom_addr;

    int n_chk = 0;
    int n_err = 0;
    bit err_m;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (o_valid) break;
            step();
        end
        chk({tag, "_valid_seen"}, 40'(o_valid), 40'(1));
    endtask

    // Transaction-level model: success iff the completion lands within TIMEOUT wait cycles.
    task automatic host_txn(input string tag, input bit is_rd, input logic [7:0] a,
                            input logic [31:0] d, input int lat, input bit no_rdv,
                            input bit mid_start, input int to);
        bit          ok_m;
        int          exp_step;
        int          got;
        logic [31:0] exp_rd;
        ok_m     = (lat <= to) && !(is_rd && no_rdv);
        exp_step = ok_m ? lat + 1 : to + 1;
        exp_rd   = ok_m ? d : 32'hFFFF_FFFF;
        if (is_rd) begin
            rd_req = 1'b1; rd_addr = a; rd_param = d;
        end else begin
            wr_req = 1'b1; wr_addr = a; wr_data = d;
        end
        wait_valid(tag);
        chk({tag, "_addr"}, 40'(o_addr), 40'(a));
        chk({tag, "_rd_en"}, 40'(o_rd_en), 40'(is_rd));
        if (!is_rd) chk({tag, "_data"}, 40'(o_data), 40'(d));
        got = 0;
        for (int k = 0; k <= exp_step + 2; k++) begin
            spi_end    = is_rd ? ((lat >= 2 && k == lat / 2) || (no_rdv && k == lat)) : (k == lat);
            rd_valid   = is_rd && !no_rdv && (k == lat);
            init_start = mid_start && (k == 1);
            step();
            if (o_wr_ack || o_rd_ack) begin
                got = k + 1;
                break;
            end
        end
        spi_end = 1'b0; rd_valid = 1'b0; init_start = 1'b0;
        if (is_rd) rd_req = 1'b0; else wr_req = 1'b0;
        err_m = err_m | !ok_m;
        chk({tag, "_ack_lat"}, 40'(got), 40'(exp_step));
        chk({tag, "_ack_kind"}, 40'({o_wr_ack, o_rd_ack}), 40'({!is_rd, is_rd}));
        chk({tag, "_err"}, 40'(o_err), 40'(err_m));
        if (is_rd) chk({tag, "_rd_data"}, 40'(o_rd_data), 40'(exp_rd));
        step();
        chk({tag, "_ioup"}, 40'(o_ioup), 40'(!is_rd && ok_m));
        chk({tag, "_ack_clr"}, 40'({o_wr_ack, o_rd_ack}), 40'(0));
        if (is_rd) chk({tag, "_rd_hold"}, 40'(o_rd_data), 40'(exp_rd));
    endtask

    task automatic run_init(input string tag, input bit pulse, input int lat);
        err_m = 1'b0;
        if (pulse) begin
            init_start = 1'b1;
            step();
            init_start = 1'b0;
            chk({tag, "_start"}, 40'({o_busy, o_done, o_err}), 40'(3'b100));
        end
        for (int e = 0; e < 3; e++) begin
            wait_valid(tag);
            chk({tag, "_addr"}, 40'(o_addr), 40'(rom_tbl[e][39:32]));
            chk({tag, "_data"}, 40'(o_data), 40'(rom_tbl[e][31:0]));
            chk({tag, "_rden_ioup_done"}, 40'({o_rd_en, o_ioup, o_done}), 40'(0));
            for (int k = 0; k <= lat; k++) begin
                spi_end = (k == lat);
                step();
            end
            spi_end = 1'b0;
        end
        chk({tag, "_done"}, 40'(o_done), 40'(1));
        step();
        chk({tag, "_ioup"}, 40'(o_ioup), 40'(1));
        step();
        chk({tag, "_end"}, 40'({o_ioup, o_busy, o_done}), 40'(3'b001));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_tbl[i] = '0;
        rom_tbl[0] = 40'h00_0000_0002;
        rom_tbl[1] = 40'h0E_0A0B_0C0D;
        rom_tbl[2] = 40'h01_0140_0820;
        rst_n = 1'b0; sel = 1'b0; err_m = 1'b0;
        init_start = 1'b0; wr_req = 1'b0; rd_req = 1'b0; spi_end = 1'b0; rd_valid = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; rd_param = '0;
        step(); step();
        chk("rst_status", 40'({o_busy, o_done, o_err, o_valid, o_ioup}), 40'(0));
        chk("rst_rom_addr", 40'(o_rom_addr), 40'(0));
        rst_n = 1'b1;
        step();

        // Long-timeout instance: directed scenarios.
        run_init("init_a", 1'b1, 20);
        host_txn("wr_a", 1'b0, 8'h0E, 32'h1234_5678, 6, 1'b0, 1'b0, TO_A);
        host_txn("rd_a", 1'b1, 8'h0E, 32'hCAFE_F00D, 4, 1'b0, 1'b0, TO_A);
        rd_req = 1'b1; rd_addr = 8'h3C;
        host_txn("both_wr", 1'b0, 8'h21, 32'h5555_AAAA, 3, 1'b0, 1'b0, TO_A);
        host_txn("both_rd", 1'b1, 8'h3C, 32'h0BAD_BEEF, 3, 1'b0, 1'b0, TO_A);
        host_txn("wr_pend", 1'b0, 8'h05, 32'h00C0_FFEE, 4, 1'b0, 1'b1, TO_A);
        run_init("init_pend", 1'b0, 3);

        // Reset while init entry 1 is waiting for completion.
        init_start = 1'b1; step(); init_start = 1'b0;
        wait_valid("rst_e0");
        for (int k = 0; k <= 20; k++) begin
            spi_end = (k == 20);
            step();
        end
        spi_end = 1'b0;
        wait_valid("rst_e1");
        chk("rst_e1_rom_addr", 40'(o_rom_addr), 40'(1));
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_status", 40'({o_busy, o_done, o_err, o_valid, o_ioup, o_rd_en}), 40'(0));
        chk("rst_mid_rom_addr", 40'(o_rom_addr), 40'(0));
        chk("rst_mid_cfg", 40'({o_addr, o_data}), 40'(0));
        chk("rst_mid_host", 40'({o_wr_ack, o_rd_ack, o_rd_data}), 40'(0));
        step();
        rst_n = 1'b1;
        step();
        run_init("init_after_rst", 1'b1, 20);

        // Short-timeout instance.
        sel = 1'b1;
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        chk("b_rst", 40'({o_busy, o_done, o_err}), 40'(0));
        err_m = 1'b0;
        host_txn("to_wr", 1'b0, 8'h0E, 32'h1234_5678, 100, 1'b0, 1'b0, TO_B);
        host_txn("edge_wr", 1'b0, 8'h22, 32'hA5A5_5A5A, TO_B, 1'b0, 1'b0, TO_B);
        host_txn("to_rd", 1'b1, 8'h0E, 32'hCAFE_F00D, 5, 1'b1, 1'b0, TO_B);
        run_init("init_clr", 1'b1, 3);
        for (int t = 0; t < 16; t++) begin
            bit          r;
            bit          nv;
            int          lat;
            logic [7:0]  a;
            logic [31:0] d;
            r   = 1'($urandom_range(0, 1));
            nv  = r && ($urandom_range(0, 3) == 0);
            lat = int'($urandom_range(0, 20));
            a   = 8'($urandom);
            d   = $urandom;
            host_txn($sformatf("rnd%0d", t), r, a, d, lat, nv, 1'b0, TO_B);
        end
        step();
        chk("final_idle", 40'(o_busy), 40'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
